// File: rtl/student_serial_and16_if.sv
// student_serial_and16_if
// Handshake bundle for the bit-serial AND engine.
//   in_valid / in_ready : operand transfer (a, b sampled when both high)
//   out_valid / out_ready: result transfer (out stable while out_valid)
//   busy                : engine is evaluating or holding a result
// master: the side that supplies operands and consumes results.
// slave : the engine itself.
interface student_serial_and16_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

// File: rtl/student_serial_and16.sv
// student_and
// Single 2-input AND gate from the gate library.
//   a, b : inputs
//   y    : a AND b
module student_and (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

// student_serial_and16
// Bit-serial WIDTH-bit AND engine. Captures an operand pair on an accepted
// input transfer, evaluates one bit per clock through one student_and gate,
// and presents the finished word on the result handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : operand/result handshakes, out word and busy flag (slave side)
module student_serial_and16 #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    student_serial_and16_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             gate_y;
    logic             accept;
    logic             last_bit;

    assign accept   = (state == IDLE) && bus.in_valid;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    student_and u_and (
        .a (a_sh[0]),
        .b (b_sh[0]),
        .y (gate_y)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nx = RUN;
            RUN:     if (last_bit)      state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // LSB-first evaluation; each result bit enters at the MSB so that after
    // WIDTH shifts bit i lands back in position i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            cnt  <= '0;
        end else if (accept) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            res  <= '0;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            res  <= {gate_y, res[WIDTH-1:1]};
            cnt  <= cnt + CW'(1);
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == RUN) || (state == DONE);
    assign bus.out       = res;
endmodule

// File: tb/tb_student_serial_and16.sv
// tb_student_serial_and16
// Randomized self-checking bench for student_serial_and16. Expected results
// come from a plain a & b reference with fixed latency/throughput numbers.
module tb_student_serial_and16;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    student_serial_and16_if #(.WIDTH(W)) bus ();

    student_serial_and16 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair, then wait (bounded) for out_valid.
    // lat is the number of edges after acceptance at which out_valid is seen,
    // or -1 on timeout.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output logic acc_ok, output int lat,
                          output logic [W-1:0] res);
        acc_ok       = bus.in_ready;
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        lat = -1;
        res = '0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (bus.out_valid) begin
                lat = c;
                res = bus.out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 16'hFFFF;
        bus.b         = 16'hFFFF;
        bus.out_ready = 1'b0;
        step();
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: in_ready=%b busy=%b out_valid=%b, required 1 0 0",
                     bus.in_ready, bus.busy, bus.out_valid);
        end
        checks++;
        if (bus.out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_out: out=%h, required 0000", bus.out);
        end
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0",
                     bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_basic();
        logic         acc;
        int           lat;
        logic [W-1:0] res;
        bus.out_ready = 1'b1;
        run_op(16'hFFFF, 16'h0F0F, acc, lat, res);
        checks++;
        if (acc !== 1'b1) begin
            failures++;
            $display("FAIL basic_accept: in_ready=%b, required 1", acc);
        end
        checks++;
        if (lat != 16) begin
            failures++;
            $display("FAIL basic_latency: latency=%0d, required 16", lat);
        end
        checks++;
        if (res !== (16'hFFFF & 16'h0F0F)) begin
            failures++;
            $display("FAIL basic_result: out=%h, required %h", res, 16'hFFFF & 16'h0F0F);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_one_cycle: out_valid=%b in_ready=%b, required 0 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_alternating();
        logic [W-1:0] av [2];
        logic [W-1:0] bv [2];
        logic         acc;
        int           lat;
        logic [W-1:0] res;
        av[0] = 16'hAAAA; bv[0] = 16'h5555;
        av[1] = 16'hC3A5; bv[1] = 16'hF00F;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            run_op(av[i], bv[i], acc, lat, res);
            checks++;
            if (res !== (av[i] & bv[i]) || lat != 16) begin
                failures++;
                $display("FAIL alternating_%0d: out=%h lat=%0d, required %h lat=16",
                         i, res, lat, av[i] & bv[i]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic         acc;
        int           lat;
        logic [W-1:0] res;
        int           viol;
        bus.out_ready = 1'b0;
        run_op(16'h1234, 16'hFFFF, acc, lat, res);
        checks++;
        if (res !== 16'h1234 || lat != 16) begin
            failures++;
            $display("FAIL bp_result: out=%h lat=%0d, required 1234 lat=16", res, lat);
        end
        viol = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.out !== 16'h1234)
                viol++;
            if (k < 4) step();
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL bp_hold: %0d cycles lost the held result, required 0", viol);
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out !== 16'h1234) begin
            failures++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b out=%h, required 0 1 1234",
                     bus.out_valid, bus.in_ready, bus.out);
        end
    endtask

    task automatic test_ignored_input();
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        int           lat;
        int           viol;
        a0 = W'($urandom);
        b0 = W'($urandom);
        bus.out_ready = 1'b1;
        bus.a         = a0;
        bus.b         = b0;
        bus.in_valid  = 1'b1;
        step();
        lat  = -1;
        viol = 0;
        for (int c = 1; c <= 40; c++) begin
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            step();
            if (bus.out_valid) begin
                lat = c;
                break;
            end
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) viol++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (lat != 16 || bus.out !== (a0 & b0)) begin
            failures++;
            $display("FAIL ignored_result: out=%h lat=%0d, required %h lat=16",
                     bus.out, lat, a0 & b0);
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL ignored_busy: %0d RUN cycles not busy, required 0", viol);
        end
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_idle: in_ready=%b busy=%b, required 1 0",
                     bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_reset_mid_op();
        logic         acc;
        int           lat;
        logic [W-1:0] res;
        int           spurious;
        bus.out_ready = 1'b1;
        bus.a         = 16'hFFFF;
        bus.b         = 16'hFFFF;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out !== 16'h0000 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_immediate: out=%h out_valid=%b busy=%b in_ready=%b, required 0000 0 0 1",
                     bus.out, bus.out_valid, bus.busy, bus.in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        spurious = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (bus.out_valid !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL midrst_spurious: out_valid seen %0d times, required 0", spurious);
        end
        run_op(16'h00FF, 16'h0FF0, acc, lat, res);
        checks++;
        if (acc !== 1'b1 || lat != 16 || res !== 16'h00F0) begin
            failures++;
            $display("FAIL midrst_fresh: acc=%b out=%h lat=%0d, required 1 00f0 lat=16",
                     acc, res, lat);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_q [$];
        int           t [3];
        int           acc;
        int           got;
        logic         took;
        logic [W-1:0] e;
        bus.out_ready = 1'b1;
        bus.a         = W'($urandom);
        bus.b         = W'($urandom);
        bus.in_valid  = 1'b1;
        acc = 0;
        got = 0;
        for (int cyc = 0; cyc < 120 && got < 3; cyc++) begin
            took = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(bus.a & bus.b);
                acc++;
                took = 1'b1;
            end
            step();
            if (took) begin
                bus.a = W'($urandom);
                bus.b = W'($urandom);
                if (acc == 3) bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                t[got] = cyc;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                checks++;
                if (bus.out !== e) begin
                    failures++;
                    $display("FAIL b2b_result_%0d: out=%h, required %h", got, bus.out, e);
                end
                got++;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != 3) begin
            failures++;
            $display("FAIL b2b_count: results=%0d, required 3", got);
        end else begin
            checks++;
            if (t[1] - t[0] != 18 || t[2] - t[1] != 18) begin
                failures++;
                $display("FAIL b2b_spacing: gaps=%0d,%0d, required 18,18",
                         t[1] - t[0], t[2] - t[1]);
            end
        end
        step();
    endtask

    task automatic test_random();
        logic         acc;
        int           lat;
        logic [W-1:0] res;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        int           hold;
        int           viol;
        for (int i = 0; i < 8; i++) begin
            av   = W'($urandom);
            bv   = W'($urandom);
            hold = int'($urandom_range(0, 3));
            bus.out_ready = 1'b0;
            run_op(av, bv, acc, lat, res);
            checks++;
            if (acc !== 1'b1 || lat != 16 || res !== (av & bv)) begin
                failures++;
                $display("FAIL random_%0d: acc=%b out=%h lat=%0d, required 1 %h lat=16",
                         i, acc, res, lat, av & bv);
            end
            viol = 0;
            for (int k = 0; k < hold; k++) begin
                step();
                if (bus.out_valid !== 1'b1 || bus.out !== (av & bv)) viol++;
            end
            bus.out_ready = 1'b1;
            step();
            checks++;
            if (viol != 0 || bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL random_hold_%0d: lost=%0d out_valid=%b, required 0 0",
                         i, viol, bus.out_valid);
            end
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_alternating();
        test_backpressure();
        test_ignored_input();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
